seg_scan_driver: RTL
====================

# seg_scan_driver

Two-digit, time-multiplexed 7-segment display driver fed by the 8-bit SEG output PIO. It consumes the PIO's `out_port` byte and snapshots it once per scan frame, so a frame never mixes old and new data. In hex mode it shows the byte as two hex digits; in raw mode it passes the byte through as a segment pattern. It drives active-low segment and digit-enable pins, and inserts a blanking gap between digits to suppress ghosting.

## Interface
Parameters:
- `DIV`, default 50000: cycles per digit slot (1 ms at 50 MHz); legal range DIV ≥ 2.
- `BLANK`, default 500: dead cycles at the start of each slot; legal range 0 ≤ BLANK < DIV.

Ports:
- `clk`  in  1: single clock; every register is on its rising edge.
- `reset_n`  in  1: reset; synchronous and active-low.
- `in_data`  in  8: display value, connected to the SEG PIO `out_port`.
- `raw_mode`  in  1: 0 = hex decode of `in_data`; 1 = `in_data` used directly as segments.
- `enable`  in  1: 1 = scan runs; 0 = display dark.
- `seg_n`  out  7: segments a..g, active-low; bit 0 = a, bit 6 = g.
- `dp_n`  out  1: decimal point, active-low.
- `dig_n`  out  2: digit enables, active-low; bit 0 = low digit, bit 1 = high digit.
- `frame_tick`  out  1: one-cycle pulse on the cycle a new snapshot is taken.

## Operation
- Reset (`reset_n`=0 at a rising edge) gives:
  - state IDLE, slot counter 0, shadow byte and shadow mode 0;
  - `seg_n`=7'h7F, `dp_n`=1, `dig_n`=2'b11, `frame_tick`=0.
- State machine: IDLE, BLANK0, SHOW0, BLANK1, SHOW1.
  - The slot counter counts 0..DIV-1 and returns to 0 at each slot end.
  - BLANKx covers counter 0..BLANK-1; SHOWx covers BLANK..DIV-1. When BLANK=0, the BLANK states are never occupied.
  - Transitions: BLANK0 → SHOW0 → BLANK1 → SHOW1 → BLANK0 ...
  - IDLE → BLANK0 on the edge where `enable`=1 is sampled.
  - Any state → IDLE on the edge where `enable`=0 is sampled. The counter clears at the same time.
- Snapshot:
  - `in_data` and `raw_mode` are copied into the shadow registers on entry to slot 0, both from IDLE and from SHOW1.
  - `frame_tick`=1 for exactly that one cycle.
  - Changes to `in_data` at any other time have no effect until the next frame.
- Hex mode (shadow mode = 0):
  - Digit 0 shows shadow[3:0]; digit 1 shows shadow[7:4]; `dp_n`=1.
  - Active-high gfedcba patterns, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - `seg_n` is the bitwise inverse of the pattern.
- Raw mode (shadow mode = 1):
  - Digit 0 shows `seg_n`=~shadow[6:0] and `dp_n`=~shadow[7].
  - Digit 1 stays off for the whole SHOW1 slot; slot timing is unchanged.
- Output levels by state:
  - IDLE and BLANKx: `dig_n`=2'b11, `seg_n`=7'h7F, `dp_n`=1.
  - SHOW0: `dig_n`=2'b10.
  - SHOW1: `dig_n`=2'b01.
- Simultaneous events:
  - `reset_n`=0 overrides `enable`.
  - `enable` falling on the same edge as a slot boundary goes to IDLE; no snapshot is taken.

## Timing
- All outputs are registered. Segment, dp and digit-enable values change on the same edge, so no glitch between them.
- Frame length is 2·DIV cycles. Each digit is lit for DIV-BLANK cycles per frame.
- `enable` sampled 1 at edge t:
  - cycle t+1: BLANK0, `frame_tick`=1;
  - cycle t+1+BLANK: `dig_n`[0] first goes low.
- `enable` sampled 0 at edge t: all outputs are off in cycle t+1.
- `frame_tick` repeats every 2·DIV cycles while enabled.
- The slot counter is $clog2(DIV) bits wide and compares against DIV-1 exactly. It does not overflow.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking. In hex mode with shadow[7:4]=0, digit 1 stays off (`dig_n`[1]=1) during SHOW1.
- `SEG_LZB_EN` undefined: digit 1 always shows its nibble, including "0" (`seg_n`=7'h40).
- The macro has no effect in raw mode.

## Test plan
All scenarios use DIV=8 and BLANK=2.
- Reset: hold `reset_n`=0 for 3 cycles with `enable`=1. Required: `seg_n`=7'h7F, `dp_n`=1, `dig_n`=2'b11, `frame_tick`=0 throughout; the first `frame_tick` comes one cycle after release.
- Hex 0x81, `raw_mode`=0, `enable`=1. Required:
  - SHOW0 lasts 6 cycles with `dig_n`=2'b10, `seg_n`=7'h79;
  - SHOW1 lasts 6 cycles with `dig_n`=2'b01, `seg_n`=7'h00;
  - `frame_tick` period is 16 cycles.
- Tear-free update: change `in_data` from 0x81 to 0x3C during SHOW0. Required: the rest of that frame shows 1/8; the next frame shows C (`seg_n`=7'h46) and 3 (`seg_n`=7'h30).
- Raw 0xA5, `raw_mode`=1. Required: SHOW0 has `seg_n`=7'h5A and `dp_n`=0; SHOW1 has `dig_n`=2'b11.
- `enable` dropped mid-SHOW1. Required: the next cycle is all-off with no `frame_tick`. Re-raising `enable` gives `frame_tick` one cycle later.
- Value 0x07, run twice. Required: with `SEG_LZB_EN` defined, `dig_n`=2'b11 throughout SHOW1; without it, `dig_n`=2'b01 and `seg_n`=7'h40 during SHOW1.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - two-digit multiplexed 7-segment scan driver; optional leading-zero blanking via SEG_LZB_EN
module seg_scan_driver #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       raw_mode,
  input  logic       enable,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [1:0] dig_n,
  output logic       frame_tick
);

  localparam int              CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   C_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]   C_BLANK = CW'(BLANK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLANK0,
    S_SHOW0,
    S_BLANK1,
    S_SHOW1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_sh_data;
  logic            r_sh_raw;
  logic [6:0]      r_seg_n;
  logic            r_dp_n;
  logic [1:0]      r_dig_n;
  logic            r_frame_tick;

  state_t          w_state_nxt;
  state_t          w_slot0_start;
  state_t          w_slot1_start;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_snap;
  logic            w_in_slot0;
  logic [7:0]      w_sh_data;
  logic            w_sh_raw;
  logic            w_dig1_on;
  logic [6:0]      w_seg_n;
  logic            w_dp_n;
  logic [1:0]      w_dig_n;

  // Active-high gfedcba pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Next state, slot counter, snapshot strobe and the output levels for the next cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_snap        = 1'b0;
    w_slot0_start = (BLANK == 0) ? S_SHOW0 : S_BLANK0;
    w_slot1_start = (BLANK == 0) ? S_SHOW1 : S_BLANK1;
    w_in_slot0    = (r_state == S_BLANK0) || (r_state == S_SHOW0);

    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == S_IDLE) begin
      w_state_nxt = w_slot0_start;
      w_cnt_nxt   = '0;
      w_snap      = 1'b1;
    end else if (r_cnt == C_LAST) begin
      w_cnt_nxt = '0;
      if (w_in_slot0) begin
        w_state_nxt = w_slot1_start;
      end else begin
        w_state_nxt = w_slot0_start;
        w_snap      = 1'b1;
      end
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (w_cnt_nxt == C_BLANK) begin
        w_state_nxt = w_in_slot0 ? S_SHOW0 : S_SHOW1;
      end
    end

    // Outputs are computed from the shadow as it will be next cycle, so a
    // freshly snapshotted frame is displayed from its very first cycle.
    w_sh_data = w_snap ? in_data  : r_sh_data;
    w_sh_raw  = w_snap ? raw_mode : r_sh_raw;

`ifdef SEG_LZB_EN
    w_dig1_on = (w_sh_data[7:4] != 4'h0);
`else
    w_dig1_on = 1'b1;
`endif

    w_seg_n = 7'h7F;
    w_dp_n  = 1'b1;
    w_dig_n = 2'b11;
    case (w_state_nxt)
      S_SHOW0: begin
        w_dig_n = 2'b10;
        if (w_sh_raw) begin
          w_seg_n = ~w_sh_data[6:0];
          w_dp_n  = ~w_sh_data[7];
        end else begin
          w_seg_n = ~hex7(w_sh_data[3:0]);
        end
      end
      S_SHOW1: begin
        if (!w_sh_raw && w_dig1_on) begin
          w_dig_n = 2'b01;
          w_seg_n = ~hex7(w_sh_data[7:4]);
        end
      end
      default: begin
        w_dig_n = 2'b11;
      end
    endcase
  end

  // State, counter, shadow and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sh_data    <= 8'h00;
      r_sh_raw     <= 1'b0;
      r_seg_n      <= 7'h7F;
      r_dp_n       <= 1'b1;
      r_dig_n      <= 2'b11;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sh_data    <= w_sh_data;
      r_sh_raw     <= w_sh_raw;
      r_seg_n      <= w_seg_n;
      r_dp_n       <= w_dp_n;
      r_dig_n      <= w_dig_n;
      r_frame_tick <= w_snap;
    end
  end

  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign dig_n      = r_dig_n;
  assign frame_tick = r_frame_tick;

endmodule
